// File: rtl/coriolis_ker0_add6_pkg.sv
// Shared coriolis stream package: default width, pointer-width helper, beat type.
package coriolis_pkg;

    localparam int unsigned STREAMW_DEF = 32;

    // Pointer width for a FIFO of the given depth (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One stream beat at the default width: payload plus its valid qualifier.
    typedef struct packed {
        logic                   valid;
        logic [STREAMW_DEF-1:0] data;
    } beat_t;

endpackage

// File: rtl/coriolis_stream_fifo.sv
// Small elastic FIFO with a combinational head; a full FIFO refuses pushes
// even when it pops in the same cycle (no pass-through path).
module coriolis_stream_fifo
    import coriolis_pkg::*;
#(
    parameter int unsigned STREAMW    = STREAMW_DEF,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [STREAMW-1:0] din,
    output logic               full,
    input  logic               pop,
    output logic [STREAMW-1:0] dout,
    output logic               empty
);

    localparam int unsigned PW = ptr_w(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [STREAMW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               do_push_c, do_pop_c;

    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        do_push_c = push && !full;
        do_pop_c  = pop && !empty;
        wr_ptr_d  = wr_ptr_q + PW'(do_push_c);
        rd_ptr_d  = rd_ptr_q + PW'(do_pop_c);
        cnt_d     = cnt_q + CW'(do_push_c) - CW'(do_pop_c);
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/coriolis_ker0_add6.sv
// Two-input streaming adder: per-input elastic FIFOs, in-order join, registered sum.
// Optional sticky signed-overflow flag enabled by defining CORIOLIS_ADD_OVF_EN.
module coriolis_ker0_add6
    import coriolis_pkg::*;
#(
    parameter int unsigned STREAMW    = STREAMW_DEF,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid_in1,
    input  logic [STREAMW-1:0] in1,
    output logic               iready_in1,
    input  logic               ivalid_in2,
    input  logic [STREAMW-1:0] in2,
    output logic               iready_in2,
    output logic               ovalid,
    output logic [STREAMW-1:0] out1,
`ifdef CORIOLIS_ADD_OVF_EN
    output logic               ovf,
`endif
    input  logic               oready
);

    logic               full1, empty1, full2, empty2;
    logic [STREAMW-1:0] head1, head2;
    logic               push1_c, push2_c;
    logic               out_free_c, fire_c;
    logic [STREAMW-1:0] sum_c;
    logic [STREAMW-1:0] out_q, out_d;
    logic               ovalid_q, ovalid_d;

    // Ready depends only on reset and FIFO state, never on oready.
    assign iready_in1 = rst && !full1;
    assign iready_in2 = rst && !full2;
    assign push1_c    = ivalid_in1 && iready_in1;
    assign push2_c    = ivalid_in2 && iready_in2;

    coriolis_stream_fifo #(
        .STREAMW    (STREAMW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1_c),
        .din   (in1),
        .full  (full1),
        .pop   (fire_c),
        .dout  (head1),
        .empty (empty1)
    );

    coriolis_stream_fifo #(
        .STREAMW    (STREAMW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo2 (
        .clk   (clk),
        .rst   (rst),
        .push  (push2_c),
        .din   (in2),
        .full  (full2),
        .pop   (fire_c),
        .dout  (head2),
        .empty (empty2)
    );

    // Join both heads when the output register can take a new sum.
    always_comb begin
        out_free_c = !ovalid_q || oready;
        fire_c     = !empty1 && !empty2 && out_free_c;
        sum_c      = head1 + head2;
        out_d      = out_q;
        ovalid_d   = ovalid_q;
        if (fire_c) begin
            out_d    = sum_c;
            ovalid_d = 1'b1;
        end else if (oready) begin
            ovalid_d = 1'b0;
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q    <= '0;
            ovalid_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign out1   = out_q;
    assign ovalid = ovalid_q;

`ifdef CORIOLIS_ADD_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky flag: operands share a sign but the wrapped sum does not.
    always_comb begin
        ovf_d = ovf_q;
        if (fire_c && (head1[STREAMW-1] == head2[STREAMW-1]) &&
            (sum_c[STREAMW-1] != head1[STREAMW-1])) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_coriolis_ker0_add6.sv
// Self-checking bench for coriolis_ker0_add6 (build with CORIOLIS_ADD_OVF_EN for ovf).
module tb_coriolis_ker0_add6;

    logic        clk;
    logic        rst;
    logic        ivalid_in1, ivalid_in2;
    logic [31:0] in1, in2;
    logic        iready_in1, iready_in2;
    logic        ovalid;
    logic [31:0] out1;
    logic        oready;
`ifdef CORIOLIS_ADD_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: arrival-ordered operand queues and the expected sum queue.
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] expq[$];

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    coriolis_ker0_add6 #(
        .STREAMW    (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ivalid_in1 (ivalid_in1),
        .in1        (in1),
        .iready_in1 (iready_in1),
        .ivalid_in2 (ivalid_in2),
        .in2        (in2),
        .iready_in2 (iready_in2),
        .ovalid     (ovalid),
        .out1       (out1),
`ifdef CORIOLIS_ADD_OVF_EN
        .ovf        (ovf),
`endif
        .oready     (oready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboard at the falling edge: observes transfers that the next rising edge commits.
    always @(negedge clk) begin
        if (!rst) begin
            q1.delete();
            q2.delete();
            expq.delete();
        end else begin
            if (ovalid && oready) begin
                if (expq.size() == 0) begin
                    check("sb_unexpected_output", out1, 32'hxxxx_xxxx);
                end else begin
                    check("sb_sum", out1, expq.pop_front());
                end
            end
            if (ivalid_in1 && iready_in1) q1.push_back(in1);
            if (ivalid_in2 && iready_in2) q2.push_back(in2);
            while (q1.size() > 0 && q2.size() > 0) begin
                expq.push_back(q1.pop_front() + q2.pop_front());
            end
        end
    end

    // Present one beat on the given port and hold it until accepted (bounded).
    task automatic send(input int p, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        if (p == 1) begin ivalid_in1 = 1'b1; in1 = d; end
        else        begin ivalid_in2 = 1'b1; in2 = d; end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if ((p == 1) ? iready_in1 : iready_in2) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (p == 1) ivalid_in1 = 1'b0;
        else        ivalid_in2 = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_ovalid(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ovalid) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"aligned_0", 32'd1,         32'd10,        32'd11};
        vecs[1] = '{"aligned_1", 32'd2,         32'd20,        32'd22};
        vecs[2] = '{"aligned_2", 32'd3,         32'd30,        32'd33};
        vecs[3] = '{"aligned_3", 32'd4,         32'd40,        32'd44};
        vecs[4] = '{"wrap",      32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        vecs[5] = '{"ovf_pos",   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[6] = '{"mul5_join", 32'hFFFF_FFFB, 32'd12,        32'd7};
        vecs[7] = '{"zero",      32'd0,         32'd0,         32'd0};
        vecs[8] = '{"ovf_neg",   32'h8000_0000, 32'h8000_0000, 32'h0000_0000};

        rst = 1'b0; ivalid_in1 = 1'b0; ivalid_in2 = 1'b0;
        in1 = '0; in2 = '0; oready = 1'b1;

        // Reset state and ready gating.
        tick(1);
        check("rst_ovalid", 32'(ovalid), 32'd0);
        check("rst_out1", out1, 32'd0);
        check("rst_iready1", 32'(iready_in1), 32'd0);
        check("rst_iready2", 32'(iready_in2), 32'd0);
        rst = 1'b1;
        tick(1);
        check("post_rst_iready1", 32'(iready_in1), 32'd1);
        check("post_rst_iready2", 32'(iready_in2), 32'd1);
`ifdef CORIOLIS_ADD_OVF_EN
        check("ovf_after_reset", 32'(ovf), 32'd0);
`endif

        // Table: aligned stream, one pair per cycle, two-cycle latency.
        for (int c = 0; c <= NV; c++) begin
            if (c < NV) begin
                ivalid_in1 = 1'b1; in1 = vecs[c].a;
                ivalid_in2 = 1'b1; in2 = vecs[c].b;
            end else begin
                ivalid_in1 = 1'b0; ivalid_in2 = 1'b0;
            end
            tick(1);
            if (c == 0) begin
                check("latency_first", 32'(ovalid), 32'd0);
            end else begin
                check({vecs[c-1].name, "_valid"}, 32'(ovalid), 32'd1);
                check(vecs[c-1].name, out1, vecs[c-1].sum);
            end
        end
        tick(1);
        check("stream_end_ovalid", 32'(ovalid), 32'd0);
`ifdef CORIOLIS_ADD_OVF_EN
        check("ovf_sticky", 32'(ovf), 32'd1);
`endif

        // Skew: in1 leads by six cycles; FIFO1 fills at two entries.
        fork
            begin send(1, 32'd5); send(1, 32'd6); send(1, 32'd7); end
            begin
                repeat (6) @(posedge clk);
                #1;
                send(2, 32'd1); send(2, 32'd1); send(2, 32'd1);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("skew_iready1_full", 32'(iready_in1), 32'd0);
                check("skew_no_output", 32'(ovalid), 32'd0);
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("skew_iready1_hold", 32'(iready_in1), 32'd0);
            end
        join
        tick(4);
        check("skew_drained", 32'(expq.size()), 32'd0);

        // Back-pressure: stalled output holds; FIFOs fill then drain one per cycle.
        oready = 1'b0;
        fork
            begin send(1, 32'd50); send(1, 32'd1); send(1, 32'd3); send(1, 32'd5); end
            begin send(2, 32'd50); send(2, 32'd2); send(2, 32'd4); send(2, 32'd6); end
            begin
                logic [31:0] dr[4];
                dr[0] = 32'h64; dr[1] = 32'd3; dr[2] = 32'd7; dr[3] = 32'd11;
                wait_ovalid("bp_first_valid");
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("bp_hold_ovalid", 32'(ovalid), 32'd1);
                    check("bp_hold_out1", out1, 32'h0000_0064);
                end
                check("bp_iready1_full", 32'(iready_in1), 32'd0);
                check("bp_iready2_full", 32'(iready_in2), 32'd0);
                @(posedge clk); #1;
                oready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_drain_ovalid", 32'(ovalid), 32'd1);
                    check("bp_drain_out1", out1, dr[i]);
                end
            end
        join
        tick(3);
        check("bp_drained", 32'(expq.size()), 32'd0);

        // Mid-operation reset with both FIFOs full and a held output.
        oready = 1'b0;
        fork
            begin send(1, 32'd1);  send(1, 32'd2);  send(1, 32'd3);  end
            begin send(2, 32'd10); send(2, 32'd20); send(2, 32'd30); end
        join
        @(negedge clk);
        check("mr_pre_ovalid", 32'(ovalid), 32'd1);
        check("mr_pre_iready1", 32'(iready_in1), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mr_during_iready1", 32'(iready_in1), 32'd0);
        check("mr_during_iready2", 32'(iready_in2), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; oready = 1'b1;
        @(negedge clk);
        check("mr_ovalid", 32'(ovalid), 32'd0);
        check("mr_out1", out1, 32'd0);
        check("mr_iready1", 32'(iready_in1), 32'd1);
        check("mr_iready2", 32'(iready_in2), 32'd1);
`ifdef CORIOLIS_ADD_OVF_EN
        check("mr_ovf_cleared", 32'(ovf), 32'd0);
`endif
        repeat (2) begin
            @(negedge clk);
            check("mr_no_stale", 32'(ovalid), 32'd0);
        end
        @(posedge clk); #1;
        fork
            send(1, 32'd3);
            send(2, 32'd4);
        join
        wait_ovalid("mr_next_valid");
        check("mr_next_sum", out1, 32'd7);
        tick(2);

        // Randomized traffic with random gaps and random back-pressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    tick($urandom_range(0, 2));
                    send(1, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom()));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    tick($urandom_range(0, 3));
                    send(2, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom()));
                end
            end
            begin
                repeat (150) begin
                    @(posedge clk); #1;
                    oready = 1'($urandom_range(0, 1));
                end
                oready = 1'b1;
            end
        join
        oready = 1'b1;
        tick(6);
        check("rand_drained", 32'(expq.size()), 32'd0);
        check("rand_q1_empty", 32'(q1.size()), 32'd0);
        check("rand_q2_empty", 32'(q2.size()), 32'd0);
        check("rand_idle_ovalid", 32'(ovalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coriolis_ker0_add6.md
Name: coriolis_ker0_add6

Overview:
- Two-input streaming adder leaf node. It sits directly downstream of coriolis_ker0_mul5 and consumes its out1 stream on in1, plus a second kernel stream on in2.
- Each input gets a small elastic FIFO so the two streams can arrive skewed. Input pairs are joined, added, and registered onto a valid/ready output stream.
- The FIFOs isolate upstream stages from combinational back-pressure paths.

Parameters:
- STREAMW, 32, data width of both inputs and of the output.
- FIFO_DEPTH, 2, entries per input FIFO; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- ivalid_in1  input  1  in1 data valid.
- in1  input  STREAMW  operand A (from mul5 out1).
- iready_in1  output  1  in1 FIFO can accept.
- ivalid_in2  input  1  in2 data valid.
- in2  input  STREAMW  operand B.
- iready_in2  output  1  in2 FIFO can accept.
- ovalid  output  1  out1 holds a valid sum.
- out1  output  STREAMW  registered sum.
- oready  input  1  downstream accepts.

Behaviour:
- Reset (rst==0 at a posedge):
  - Both FIFOs are emptied: pointers and counts go to 0.
  - The output register is cleared: out1=0, ovalid=0.
  - While rst==0, iready_in1 and iready_in2 are forced to 0.
  - Reset asserted mid-operation discards all buffered and in-flight data with no partial outputs.
- Input acceptance, per input X:
  - Push occurs when ivalid_inX && iready_inX.
  - iready_inX = !fullX; it is registered-state derived with no combinational path from oready.
  - A full FIFO refuses a push even if it pops in the same cycle (no pass-through). ivalid asserted into a full FIFO is simply held off, and data is not lost.
- Output register handshake:
  - out_free = !ovalid || oready.
- Join, evaluated at each posedge:
  - fire = !empty1 && !empty2 && out_free.
  - On fire, pop both FIFO heads, load out1 with (head1 + head2) mod 2^STREAMW (carry discarded, unsigned/two's-complement wrap), and set ovalid=1.
  - If there is no fire and oready is high while ovalid is high, clear ovalid.
- Output stability:
  - While ovalid && !oready, out1 and ovalid hold stable.
  - A transfer completes on ovalid && oready.
- Throughput and latency:
  - Back-to-back transfers sustain 1 result per cycle when both inputs stream and oready stays high.
  - Latency is 2 cycles: data accepted at edge k appears with ovalid=1 after edge k+1, provided the partner operand is already present or is accepted at the same edge.
- Skew:
  - If one input leads, its FIFO fills up to FIFO_DEPTH and then deasserts its iready until the partner arrives.
  - Pairing is strictly in arrival order per input: the nth in1 is paired with the nth in2.
- Simultaneous events:
  - A push and a pop on the same FIFO in the same cycle (when not full) leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- No X on outputs after the first reset edge.

Optional Feature:
- Macro: CORIOLIS_ADD_OVF_EN.
- With the macro defined:
  - Adds output port ovf (1 bit, reset 0). It is a sticky flag set on any fire whose sum produces a signed two's-complement overflow: operand signs are equal and the result sign differs.
  - ovf clears only on reset.
  - The datapath result is unchanged (still wraps).
- Without the macro: the ovf port and its logic are absent.

Decomposition:
- Shared package coriolis_pkg:
  - STREAMW default constant.
  - clog2-based pointer-width function.
  - Stream beat typedef (data plus valid).
- Sub-module coriolis_stream_fifo (parameters STREAMW, FIFO_DEPTH):
  - Ports: push, din, full, pop, dout, empty.
  - dout is the combinational head.
  - Same clk and active-low synchronous rst.
- Instantiate the sub-module twice. The join and output register live in the top.

Test Plan:
- Aligned streaming: in1 = 1,2,3,4 and in2 = 10,20,30,40 presented on consecutive cycles, oready=1 → out1 = 11,22,33,44 on 4 consecutive cycles, first ovalid 2 cycles after the first accept.
- Skew: in1 = 5,6,7 sent 6 cycles before in2 = 1,1,1.
  - iready_in1 drops to 0 after 2 accepts (depth 2).
  - Output = 6,7,8 in order, with no duplication or loss.
- Back-pressure:
  - Hold oready=0 for 5 cycles while ovalid=1 with out1=0x0000_0064 → out1 is stable for all 5 cycles, and both FIFOs fill to 2 and then deassert iready.
  - Release oready → remaining sums drain at 1 per cycle.
- Wrap and overflow: in1=0xFFFF_FFFF, in2=0x0000_0002 → out1=0x0000_0001.
  - With CORIOLIS_ADD_OVF_EN: 0x7FFF_FFFF + 0x0000_0001 → out1=0x8000_0000 and ovf goes to 1, staying 1 through subsequent normal sums.
- Mid-operation reset: pull rst=0 for 1 cycle with 2 entries buffered in each FIFO and ovalid=1.
  - After reset: ovalid=0, out1=0, and iready is 0 during reset and 1 after.
  - No stale sums appear; the next pair 3+4 yields 7.
- Mul5 integration: feed mul5 (in1=5 → out1=-5) into in1, with in2=12 → out1=7.
